// File: rtl/sdram_pkg.sv
// Shared types for the two-client SDRAM port arbiter.
package sdram_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    RD_WAIT = 2'd2
  } arb_state_t;

  typedef logic port_id_t;

endpackage

// File: rtl/sdram_port_arb_if.sv
// Client and controller-side signal bundle for sdram_port_arb; slave is the arbiter view.
interface sdram_port_arb_if #(
  parameter int unsigned ADDR_WIDTH = 24,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  logic                  p0_rd;
  logic [BE_WIDTH-1:0]   p0_wr;
  logic [ADDR_WIDTH-1:0] p0_addr;
  logic [DATA_WIDTH-1:0] p0_wdata;
  logic                  p0_ack;
  logic                  p0_rvalid;
  logic [DATA_WIDTH-1:0] p0_rdata;

  logic                  p1_rd;
  logic [BE_WIDTH-1:0]   p1_wr;
  logic [ADDR_WIDTH-1:0] p1_addr;
  logic [DATA_WIDTH-1:0] p1_wdata;
  logic                  p1_ack;
  logic                  p1_rvalid;
  logic [DATA_WIDTH-1:0] p1_rdata;

  logic                  core_rd;
  logic [BE_WIDTH-1:0]   core_wr;
  logic [ADDR_WIDTH-1:0] core_addr;
  logic [DATA_WIDTH-1:0] core_wdata;
  logic                  core_rdy;
  logic                  core_rvalid;
  logic [DATA_WIDTH-1:0] core_rdata;

  modport slave (
    input  p0_rd, p0_wr, p0_addr, p0_wdata,
    output p0_ack, p0_rvalid, p0_rdata,
    input  p1_rd, p1_wr, p1_addr, p1_wdata,
    output p1_ack, p1_rvalid, p1_rdata,
    output core_rd, core_wr, core_addr, core_wdata,
    input  core_rdy, core_rvalid, core_rdata
  );

  modport master (
    output p0_rd, p0_wr, p0_addr, p0_wdata,
    input  p0_ack, p0_rvalid, p0_rdata,
    output p1_rd, p1_wr, p1_addr, p1_wdata,
    input  p1_ack, p1_rvalid, p1_rdata,
    input  core_rd, core_wr, core_addr, core_wdata,
    output core_rdy, core_rvalid, core_rdata
  );

endinterface

// File: rtl/sdram_rr_arb.sv
// Two-request round-robin arbiter with one-hot grant; p0 wins the first tie after reset.
module sdram_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_gnt
);

  logic r_last;  // index of the client granted most recently

  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      if (i_req == 2'b11) o_gnt = r_last ? 2'b01 : 2'b10;
      else                o_gnt = i_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         r_last <= 1'b1;
    else if (|o_gnt) r_last <= o_gnt[1];
  end

endmodule

// File: rtl/sdram_port_arb.sv
// Two-client SDRAM port arbiter, one request in flight at a time.
// Define SDRAM_ARB_TIMEOUT_EN to add a read-wait watchdog of TIMEOUT_CYCLES.
module sdram_port_arb
  import sdram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 24,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  sdram_port_arb_if.slave  bus,
  output logic             err
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32) || TIMEOUT_CYCLES == 0)
  begin : g_bad_param
    $error("sdram_port_arb: illegal DATA_WIDTH or TIMEOUT_CYCLES");
  end

  arb_state_t            r_state, w_state_nxt;
  logic                  r_rd;
  logic [BE_WIDTH-1:0]   r_wr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  port_id_t              r_owner;

  logic [1:0]            w_req, w_gnt;
  logic                  w_arb_en, w_pend, w_tmo, w_rvalid;
  port_id_t              w_sel;
  logic                  w_sel_rd;
  logic [BE_WIDTH-1:0]   w_sel_wr;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata, w_rdata;

  assign w_req    = {bus.p1_rd | (|bus.p1_wr), bus.p0_rd | (|bus.p0_wr)};
  assign w_arb_en = (r_state == IDLE) && !rst;

  sdram_rr_arb u_rr_arb (
    .clk   (clk),
    .rst   (rst),
    .i_req (w_req),
    .i_en  (w_arb_en),
    .o_gnt (w_gnt)
  );

  assign bus.p0_ack  = w_gnt[0];
  assign bus.p1_ack  = w_gnt[1];
  assign w_sel       = port_id_t'(w_gnt[1]);
  assign w_sel_rd    = w_sel ? bus.p1_rd    : bus.p0_rd;
  assign w_sel_wr    = w_sel ? bus.p1_wr    : bus.p0_wr;
  assign w_sel_addr  = w_sel ? bus.p1_addr  : bus.p0_addr;
  assign w_sel_wdata = w_sel ? bus.p1_wdata : bus.p0_wdata;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (|w_gnt) w_state_nxt = PEND;
      PEND:    if (bus.core_rdy) w_state_nxt = r_rd ? RD_WAIT : IDLE;
      RD_WAIT: if (bus.core_rvalid || w_tmo) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rd    <= 1'b0;
      r_wr    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_owner <= 1'b0;
      err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (|w_gnt) begin
        // A combined read+write request is treated as a plain read.
        r_rd    <= w_sel_rd;
        r_wr    <= w_sel_rd ? '0 : w_sel_wr;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
        r_owner <= w_sel;
      end
      if ((bus.core_rvalid && r_state != RD_WAIT) || w_tmo) err <= 1'b1;
    end
  end

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] r_tmo_cnt;

  assign w_tmo = (r_state == RD_WAIT) && (r_tmo_cnt == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || r_state != RD_WAIT) r_tmo_cnt <= '0;
    else                           r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end
`else
  assign w_tmo = 1'b0;
`endif

  assign w_pend         = (r_state == PEND) && !rst;
  assign bus.core_rd    = w_pend && r_rd;
  assign bus.core_wr    = w_pend ? r_wr : '0;
  assign bus.core_addr  = r_addr;
  assign bus.core_wdata = r_wdata;

  // A timed-out read returns zero data.
  assign w_rvalid      = (r_state == RD_WAIT) && !rst && (bus.core_rvalid || w_tmo);
  assign w_rdata       = bus.core_rvalid ? bus.core_rdata : '0;
  assign bus.p0_rvalid = w_rvalid && (r_owner == 1'b0);
  assign bus.p1_rvalid = w_rvalid && (r_owner == 1'b1);
  assign bus.p0_rdata  = bus.p0_rvalid ? w_rdata : '0;
  assign bus.p1_rdata  = bus.p1_rvalid ? w_rdata : '0;

endmodule

// File: tb/tb_sdram_port_arb.sv
// Self-checking bench for sdram_port_arb: directed scenarios plus randomized traffic
// against a transaction-level client/arbitration model.
module tb_sdram_port_arb;

  logic clk = 1'b0;
  logic rst;
  logic err;
  int   checks = 0;
  int   errors = 0;

  sdram_port_arb_if #(.ADDR_WIDTH(24), .DATA_WIDTH(32)) bus ();

  sdram_port_arb #(
    .ADDR_WIDTH     (24),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .err (err)
  );

  always #5 clk = ~clk;

  // Client-side model: outstanding request per client and the last granted client.
  logic        pend    [2];
  logic        m_rd    [2];
  logic [3:0]  m_wr    [2];
  logic [23:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  int          m_last;
  int          obs_gnt;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_clients();
    bus.p0_rd    = pend[0] & m_rd[0];
    bus.p0_wr    = pend[0] ? m_wr[0] : 4'h0;
    bus.p0_addr  = pend[0] ? m_addr[0] : 24'h0;
    bus.p0_wdata = pend[0] ? m_wdata[0] : 32'h0;
    bus.p1_rd    = pend[1] & m_rd[1];
    bus.p1_wr    = pend[1] ? m_wr[1] : 4'h0;
    bus.p1_addr  = pend[1] ? m_addr[1] : 24'h0;
    bus.p1_wdata = pend[1] ? m_wdata[1] : 32'h0;
  endtask

  task automatic post(input int n, input logic rd, input logic [3:0] wr,
                      input logic [23:0] addr, input logic [31:0] wdata);
    pend[n] = 1'b1; m_rd[n] = rd; m_wr[n] = wr; m_addr[n] = addr; m_wdata[n] = wdata;
  endtask

  task automatic post_random(input int n);
    logic       rd;
    logic [3:0] wr;
    rd = 1'($urandom_range(0, 1));
    wr = 4'($urandom_range(0, 15));
    if (!rd && wr == 4'h0) wr = 4'hF;
    post(n, rd, wr, 24'($urandom), $urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pend[0] = 1'b0; pend[1] = 1'b0;
    drive_clients();
    bus.core_rdy = 1'b0; bus.core_rvalid = 1'b0; bus.core_rdata = 32'h0;
    step(); step();
    rst = 1'b0;
    m_last = 1;
  endtask

  // One full transaction; starts and ends at posedge+1 with the DUT idle.
  task automatic run_txn(input int rdy_dly, input int rv_dly, input logic [31:0] rdat);
    int          w;
    logic        e_rd;
    logic [3:0]  e_wr;
    logic [23:0] e_addr;
    logic [31:0] e_wdata;
    w = (pend[0] && pend[1]) ? 1 - m_last : (pend[0] ? 0 : 1);
    drive_clients();
    bus.core_rdy = 1'b0; bus.core_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.p0_ack !== (w == 0) || bus.p1_ack !== (w == 1)) begin
      errors++;
      $display("FAIL grant: p0_ack=%b p1_ack=%b, wanted winner p%0d", bus.p0_ack, bus.p1_ack, w);
    end
    checks++;
    if (bus.core_rd !== 1'b0 || bus.core_wr !== 4'h0) begin
      errors++;
      $display("FAIL idle_core: core_rd=%b core_wr=%h, wanted 0/0", bus.core_rd, bus.core_wr);
    end
    obs_gnt = bus.p1_ack ? 1 : 0;
    e_rd = m_rd[w]; e_wr = e_rd ? 4'h0 : m_wr[w]; e_addr = m_addr[w]; e_wdata = m_wdata[w];
    m_last = w; pend[w] = 1'b0;
    step();
    drive_clients();
    for (int i = 0; i <= rdy_dly; i++) begin
      bus.core_rdy = (i == rdy_dly);
      @(negedge clk);
      checks++;
      if (bus.core_rd !== e_rd || bus.core_wr !== e_wr || bus.core_addr !== e_addr ||
          (!e_rd && bus.core_wdata !== e_wdata)) begin
        errors++;
        $display("FAIL pend_issue: rd=%b wr=%h addr=%h wdata=%h, wanted rd=%b wr=%h addr=%h wdata=%h",
                 bus.core_rd, bus.core_wr, bus.core_addr, bus.core_wdata,
                 e_rd, e_wr, e_addr, e_wdata);
      end
      checks++;
      if (bus.p0_ack !== 1'b0 || bus.p1_ack !== 1'b0) begin
        errors++;
        $display("FAIL pend_ack: p0_ack=%b p1_ack=%b, wanted 0/0", bus.p0_ack, bus.p1_ack);
      end
      step();
    end
    bus.core_rdy = 1'b0;
    if (e_rd) begin
      for (int i = 0; i <= rv_dly; i++) begin
        bus.core_rvalid = (i == rv_dly);
        bus.core_rdata  = (i == rv_dly) ? rdat : $urandom;
        @(negedge clk);
        checks++;
        if (bus.p0_rvalid !== (i == rv_dly && w == 0) || bus.p1_rvalid !== (i == rv_dly && w == 1) ||
            bus.p0_rdata !== ((i == rv_dly && w == 0) ? rdat : 32'h0) ||
            bus.p1_rdata !== ((i == rv_dly && w == 1) ? rdat : 32'h0)) begin
          errors++;
          $display("FAIL rd_return: p0 %b/%h p1 %b/%h, wanted owner p%0d valid=%0d data %h",
                   bus.p0_rvalid, bus.p0_rdata, bus.p1_rvalid, bus.p1_rdata, w,
                   (i == rv_dly), rdat);
        end
        checks++;
        if (bus.core_rd !== 1'b0 || bus.core_wr !== 4'h0 || bus.p0_ack !== 1'b0 ||
            bus.p1_ack !== 1'b0) begin
          errors++;
          $display("FAIL rd_wait_quiet: core_rd=%b core_wr=%h acks=%b%b, wanted all 0",
                   bus.core_rd, bus.core_wr, bus.p1_ack, bus.p0_ack);
        end
        step();
      end
      bus.core_rvalid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    post(0, 1'b0, 4'hF, 24'h000123, 32'hCAFEF00D);
    drive_clients();
    bus.core_rdy = 1'b1; bus.core_rvalid = 1'b1; bus.core_rdata = 32'hA5A5A5A5;
    step(); step();
    @(negedge clk);
    checks++;
    if (bus.p0_ack !== 1'b0 || bus.p1_ack !== 1'b0 || bus.core_rd !== 1'b0 ||
        bus.core_wr !== 4'h0 || bus.core_addr !== 24'h0 || bus.core_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: acks=%b%b rd=%b wr=%h addr=%h wdata=%h, wanted all 0",
               bus.p1_ack, bus.p0_ack, bus.core_rd, bus.core_wr, bus.core_addr, bus.core_wdata);
    end
    checks++;
    if (bus.p0_rvalid !== 1'b0 || bus.p1_rvalid !== 1'b0 || bus.p0_rdata !== 32'h0 ||
        bus.p1_rdata !== 32'h0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_rvalid_err: rv=%b%b rdata=%h/%h err=%b, wanted all 0",
               bus.p1_rvalid, bus.p0_rvalid, bus.p1_rdata, bus.p0_rdata, err);
    end
    do_reset();
  endtask

  task automatic test_write();
    do_reset();
    post(0, 1'b0, 4'hF, 24'h000010, 32'hDEADBEEF);
    run_txn(0, 0, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.core_wr !== 4'h0 || bus.core_rd !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL write_back_idle: core_wr=%h core_rd=%b err=%b, wanted 0/0/0",
               bus.core_wr, bus.core_rd, err);
    end
    step();
  endtask

  task automatic test_read_wait();
    post(1, 1'b1, 4'h0, 24'h000020, 32'h0);
    run_txn(5, 3, 32'h12345678);
  endtask

  task automatic test_rd_wr_conflict();
    post(0, 1'b1, 4'h3, 24'h000044, 32'h55AA55AA);
    run_txn(1, 0, 32'h0BADC0DE);
  endtask

  task automatic test_round_robin();
    do_reset();
    post(0, 1'b0, 4'hF, 24'h000100, 32'h00000000);
    post(1, 1'b0, 4'hF, 24'h000200, 32'h11111111);
    for (int k = 0; k < 4; k++) begin
      run_txn(k % 2, 0, 32'h0);
      checks++;
      if (obs_gnt !== k % 2) begin
        errors++;
        $display("FAIL rr_order: grant %0d went to p%0d, wanted p%0d", k, obs_gnt, k % 2);
      end
      post(m_last, 1'b0, 4'hF, 24'($urandom), $urandom);
    end
    pend[0] = 1'b0; pend[1] = 1'b0;
    drive_clients();
  endtask

  task automatic test_err();
    do_reset();
    bus.core_rvalid = 1'b1; bus.core_rdata = 32'hFFFF0000;
    @(negedge clk);
    checks++;
    if (bus.p0_rvalid !== 1'b0 || bus.p1_rvalid !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL stray_rvalid: rv=%b%b err=%b, wanted 0/0/0", bus.p1_rvalid, bus.p0_rvalid, err);
    end
    step();
    bus.core_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (err !== 1'b1) begin
        errors++;
        $display("FAIL err_sticky: cycle %0d err=%b, wanted 1", i, err);
      end
      step();
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: err=%b, wanted 0 after reset", err);
    end
    step();
  endtask

  // Enter RD_WAIT with a p0 read then reset; no rvalid may come out afterwards.
  task automatic test_reset_midflight();
    do_reset();
    post(0, 1'b1, 4'h0, 24'h000300, 32'h0);
    drive_clients();
    step();
    pend[0] = 1'b0; drive_clients();
    bus.core_rdy = 1'b1;
    step();
    bus.core_rdy = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0; m_last = 1;
    for (int i = 0; i < 12; i++) begin
      bus.core_rvalid = (i == 0); bus.core_rdata = 32'h77777777;
      @(negedge clk);
      checks++;
      if (bus.p0_rvalid !== 1'b0 || bus.p1_rvalid !== 1'b0 || bus.p0_rdata !== 32'h0) begin
        errors++;
        $display("FAIL reset_abandon: cycle %0d rv=%b%b rdata=%h, wanted none", i,
                 bus.p1_rvalid, bus.p0_rvalid, bus.p0_rdata);
      end
      step();
    end
    bus.core_rvalid = 1'b0;
    do_reset();
  endtask

`ifdef SDRAM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    post(1, 1'b1, 4'h0, 24'h000400, 32'h0);
    drive_clients();
    step();
    pend[1] = 1'b0; drive_clients();
    bus.core_rdy = 1'b1;
    step();
    bus.core_rdy = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (bus.p1_rvalid !== (k == 7) || bus.p1_rdata !== 32'h0 || bus.p0_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL timeout_pulse: cycle %0d p1 %b/%h p0 %b, wanted p1 valid=%0d data 0",
                 k, bus.p1_rvalid, bus.p1_rdata, bus.p0_rvalid, (k == 7));
      end
      step();
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || bus.p1_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err: err=%b p1_rvalid=%b, wanted 1/0", err, bus.p1_rvalid);
    end
    step();
    post(0, 1'b0, 4'h1, 24'h000404, 32'h000000AB);
    run_txn(0, 0, 32'h0);
    do_reset();
    post(0, 1'b1, 4'h0, 24'h000408, 32'h0);
    drive_clients();
    step();
    pend[0] = 1'b0; drive_clients();
    bus.core_rdy = 1'b1;
    step();
    bus.core_rdy = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0; m_last = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (bus.p0_rvalid !== 1'b0 || bus.p1_rvalid !== 1'b0 || err !== 1'b0) begin
        errors++;
        $display("FAIL timeout_rst: cycle %0d rv=%b%b err=%b, wanted 0/0/0", i,
                 bus.p1_rvalid, bus.p0_rvalid, err);
      end
      step();
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int it = 0; it < 80; it++) begin
      for (int n = 0; n < 2; n++)
        if (!pend[n] && $urandom_range(0, 2) != 0) post_random(n);
      if (!pend[0] && !pend[1]) post_random(int'($urandom_range(0, 1)));
      run_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL random_err: err=%b after legal traffic, wanted 0", err);
    end
    step();
    pend[0] = 1'b0; pend[1] = 1'b0;
    drive_clients();
  endtask

  initial begin
    pend[0] = 1'b0; pend[1] = 1'b0;
    m_rd[0] = 1'b0; m_rd[1] = 1'b0;
    m_wr[0] = 4'h0; m_wr[1] = 4'h0;
    m_addr[0] = 24'h0; m_addr[1] = 24'h0;
    m_wdata[0] = 32'h0; m_wdata[1] = 32'h0;
    m_last = 1; obs_gnt = 0;
    test_reset();
    test_write();
    test_read_wait();
    test_rd_wr_conflict();
    test_round_robin();
    test_err();
    test_reset_midflight();
`ifdef SDRAM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_port_arb.md
SDRAM_PORT_ARB -- requirements
Module: sdram_port_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 24, byte address width shared by clients and controller side.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, legal values 8, 16 or 32; BE_WIDTH = DATA_WIDTH/8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64, read-wait watchdog limit.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have, per client n in {0,1}: pn_rd (input, 1, read request); pn_wr (input, BE_WIDTH, write byte enables); pn_addr (input, ADDR_WIDTH); pn_wdata (input, DATA_WIDTH); pn_ack (output, 1, request accepted); pn_rvalid (output, 1, read data valid); pn_rdata (output, DATA_WIDTH).
REQ-007 SHALL have controller-side ports: core_rd (output, 1); core_wr (output, BE_WIDTH); core_addr (output, ADDR_WIDTH); core_wdata (output, DATA_WIDTH); core_rdy (input, 1); core_rvalid (input, 1); core_rdata (input, DATA_WIDTH).
REQ-008 SHALL have port err, output, 1, sticky protocol-error flag.

Function
REQ-009 A client request SHALL be pn_rd=1 or pn_wr!=0; the client holds it stable until pn_ack.
REQ-010 State machine SHALL have states IDLE, PEND, RD_WAIT.
REQ-011 IDLE: with any request present, SHALL grant one client, pulse its pn_ack combinationally that cycle, capture addr/wdata/rd/wr into a hold register, and enter PEND next cycle.
REQ-012 Arbitration SHALL be round-robin: with both clients requesting, the client not granted last wins; after reset, p0 wins the first tie.
REQ-013 When pn_rd=1 and pn_wr!=0 together, the request SHALL be captured as a read, with wr cleared to 0.
REQ-014 PEND: core_rd/core_wr/core_addr/core_wdata SHALL be driven from the hold register and held stable until a cycle with core_rdy=1.
REQ-015 On the core_rdy=1 cycle in PEND, a read SHALL go to RD_WAIT recording the owner; a write SHALL go to IDLE.
REQ-016 core_rd SHALL be 0 and core_wr SHALL be 0 in IDLE and RD_WAIT.
REQ-017 RD_WAIT: on core_rvalid=1, SHALL assert the owner's pn_rvalid and drive its pn_rdata = core_rdata in the same cycle (zero latency), then enter IDLE.
REQ-018 pn_rvalid SHALL be 0 and pn_rdata SHALL be 0 for non-owners and outside RD_WAIT.
REQ-019 core_rvalid in IDLE or PEND SHALL be dropped and SHALL set err.
REQ-020 No new grant SHALL occur in PEND or RD_WAIT; at most one request is in flight.
REQ-021 Worst-case ack-to-core-issue latency SHALL be 1 cycle plus core_rdy wait, e.g. for refresh.

Reset
REQ-022 On rst: state=IDLE, hold register=0, owner=0, RR pointer favours p0, err=0, all outputs 0.
REQ-023 rst mid-PEND or mid-RD_WAIT SHALL abandon the transaction without a pn_rvalid.

Configuration
REQ-024 Macro SDRAM_ARB_TIMEOUT_EN defined: a counter SHALL run in RD_WAIT; if it reaches TIMEOUT_CYCLES without core_rvalid, the block SHALL pulse the owner's pn_rvalid with pn_rdata=0, set err, and return to IDLE.
REQ-025 Macro SDRAM_ARB_TIMEOUT_EN undefined: no counter SHALL be present, and RD_WAIT SHALL wait indefinitely.

Structure
REQ-026 Package sdram_pkg SHALL hold the arb_state_t enum (IDLE, PEND, RD_WAIT) and the port_id_t typedef (1 bit).
REQ-027 Round-robin grant logic SHALL be one sub-module, sdram_rr_arb (2 requests, 1-hot grant, last-grant pointer).

Verification
REQ-028 p0 write of addr 0x000010, wr=4'hF, wdata 0xDEADBEEF with core_rdy=1 -> p0_ack in cycle 0; core_wr=4'hF and addr 0x000010 in cycle 1; back in IDLE in cycle 2.
REQ-029 p1 read of 0x000020, core_rdy=0 for 5 cycles then 1, core_rvalid 4 cycles later with 0x12345678 -> core_rd held stable for 6 cycles; p1_rvalid=1 and p1_rdata=0x12345678 in the same cycle; p0_rvalid=0.
REQ-030 p0 and p1 both requesting continuously, writes -> grant order p0,p1,p0,p1; no ack while PEND.
REQ-031 p0 rd=1 with wr=4'h3 -> core_rd=1 and core_wr=0.
REQ-032 core_rvalid pulse in IDLE -> err=1 and stays 1 until rst; no pn_rvalid.
REQ-033 With SDRAM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, a read with no core_rvalid -> owner pn_rvalid with data 0 after 8 cycles in RD_WAIT, err=1; rst during RD_WAIT -> IDLE and no rvalid.
